tt_um_emern_rasterizer: RTL and testbench

//  Per-pixel rasterizer directly downstream of the SPI frontend. Snapshots the frontend's polygon,

---
 rtl/tt_um_emern_rasterizer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_tt_um_emern_rasterizer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_emern_rasterizer.sv
// Per-pixel two-triangle rasterizer: per-frame shadow registers, then a 3-stage pipeline
// that computes edge functions, resolves coverage by depth and emits one colour per pixel.
module tt_um_emern_rasterizer #(
    parameter int unsigned X_W     = 7,
    parameter int unsigned Y_W     = 6,
    parameter int unsigned COLOR_W = 6,
    parameter int unsigned DEPTH_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   pixel_valid,
    input  logic [X_W-1:0]         pixel_x,
    input  logic [Y_W-1:0]         pixel_y,
    input  logic [COLOR_W-1:0]     bg_color_in,
    input  logic [2*COLOR_W-1:0]   poly_color_in,
    input  logic [2*X_W-1:0]       v0_x_in,
    input  logic [2*X_W-1:0]       v1_x_in,
    input  logic [2*X_W-1:0]       v2_x_in,
    input  logic [2*Y_W-1:0]       v0_y_in,
    input  logic [2*Y_W-1:0]       v1_y_in,
    input  logic [2*Y_W-1:0]       v2_y_in,
    input  logic [2*DEPTH_W-1:0]   poly_depth_in,
    input  logic                   en_screen_in,
    input  logic [1:0]             poly_enable_in,
    output logic [COLOR_W-1:0]     color_out,
    output logic                   color_valid
);

    localparam int unsigned XD = X_W + 1;
    localparam int unsigned YD = Y_W + 1;
    localparam int unsigned PW = X_W + Y_W + 2;
    localparam int unsigned EW = PW + 1;

    function automatic logic signed [XD-1:0] xdiff(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [YD-1:0] ydiff(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // Shadow copies of the frontend registers, refreshed only on frame_start
    logic [COLOR_W-1:0]   bg_s;
    logic [2*COLOR_W-1:0] col_s;
    logic [2*X_W-1:0]     v0x_s, v1x_s, v2x_s;
    logic [2*Y_W-1:0]     v0y_s, v1y_s, v2y_s;
    logic [2*DEPTH_W-1:0] dep_s;
    logic                 scr_s;
    logic [1:0]           en_s;

    logic [COLOR_W-1:0]   bg_c;
    logic [2*COLOR_W-1:0] col_c;
    logic [2*X_W-1:0]     v0x_c, v1x_c, v2x_c;
    logic [2*Y_W-1:0]     v0y_c, v1y_c, v2y_c;
    logic [2*DEPTH_W-1:0] dep_c;
    logic                 scr_c;
    logic [1:0]           en_c;

    // A pixel arriving with frame_start already renders with the new values
    always_comb begin
        bg_c  = frame_start ? bg_color_in    : bg_s;
        col_c = frame_start ? poly_color_in  : col_s;
        v0x_c = frame_start ? v0_x_in        : v0x_s;
        v1x_c = frame_start ? v1_x_in        : v1x_s;
        v2x_c = frame_start ? v2_x_in        : v2x_s;
        v0y_c = frame_start ? v0_y_in        : v0y_s;
        v1y_c = frame_start ? v1_y_in        : v1y_s;
        v2y_c = frame_start ? v2_y_in        : v2y_s;
        dep_c = frame_start ? poly_depth_in  : dep_s;
        scr_c = frame_start ? en_screen_in   : scr_s;
        en_c  = frame_start ? poly_enable_in : en_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bg_s  <= '0;
            col_s <= '0;
            v0x_s <= '0;
            v1x_s <= '0;
            v2x_s <= '0;
            v0y_s <= '0;
            v1y_s <= '0;
            v2y_s <= '0;
            dep_s <= '0;
            scr_s <= 1'b0;
            en_s  <= '0;
        end else if (frame_start) begin
            bg_s  <= bg_color_in;
            col_s <= poly_color_in;
            v0x_s <= v0_x_in;
            v1x_s <= v1_x_in;
            v2x_s <= v2_x_in;
            v0y_s <= v0_y_in;
            v1y_s <= v1_y_in;
            v2y_s <= v2_y_in;
            dep_s <= poly_depth_in;
            scr_s <= en_screen_in;
            en_s  <= poly_enable_in;
        end
    end

    // S1: edge vectors (index 0: v0->v1, 1: v1->v2, 2: v2->v0) and pixel offsets from each vertex
    logic signed [XD-1:0] ex_d [2][3];
    logic signed [YD-1:0] ey_d [2][3];
    logic signed [XD-1:0] px_d [2][3];
    logic signed [YD-1:0] py_d [2][3];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ex_d[p][0] = xdiff(v1x_c[p*X_W +: X_W], v0x_c[p*X_W +: X_W]);
            ex_d[p][1] = xdiff(v2x_c[p*X_W +: X_W], v1x_c[p*X_W +: X_W]);
            ex_d[p][2] = xdiff(v0x_c[p*X_W +: X_W], v2x_c[p*X_W +: X_W]);
            ey_d[p][0] = ydiff(v1y_c[p*Y_W +: Y_W], v0y_c[p*Y_W +: Y_W]);
            ey_d[p][1] = ydiff(v2y_c[p*Y_W +: Y_W], v1y_c[p*Y_W +: Y_W]);
            ey_d[p][2] = ydiff(v0y_c[p*Y_W +: Y_W], v2y_c[p*Y_W +: Y_W]);
            px_d[p][0] = xdiff(pixel_x, v0x_c[p*X_W +: X_W]);
            px_d[p][1] = xdiff(pixel_x, v1x_c[p*X_W +: X_W]);
            px_d[p][2] = xdiff(pixel_x, v2x_c[p*X_W +: X_W]);
            py_d[p][0] = ydiff(pixel_y, v0y_c[p*Y_W +: Y_W]);
            py_d[p][1] = ydiff(pixel_y, v1y_c[p*Y_W +: Y_W]);
            py_d[p][2] = ydiff(pixel_y, v2y_c[p*Y_W +: Y_W]);
        end
    end

    logic                 v1_q;
    logic signed [XD-1:0] ex_q [2][3];
    logic signed [YD-1:0] ey_q [2][3];
    logic signed [XD-1:0] px_q [2][3];
    logic signed [YD-1:0] py_q [2][3];
    logic [2*COLOR_W-1:0] col1_q;
    logic [2*DEPTH_W-1:0] dep1_q;
    logic [COLOR_W-1:0]   bg1_q;
    logic                 scr1_q;
    logic [1:0]           en1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            col1_q <= '0;
            dep1_q <= '0;
            bg1_q  <= '0;
            scr1_q <= 1'b0;
            en1_q  <= '0;
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < 3; i++) begin
                    ex_q[p][i] <= '0;
                    ey_q[p][i] <= '0;
                    px_q[p][i] <= '0;
                    py_q[p][i] <= '0;
                end
            end
        end else begin
            v1_q <= pixel_valid;
            if (pixel_valid) begin
                col1_q <= col_c;
                dep1_q <= dep_c;
                bg1_q  <= bg_c;
                scr1_q <= scr_c;
                en1_q  <= en_c;
                ex_q   <= ex_d;
                ey_q   <= ey_d;
                px_q   <= px_d;
                py_q   <= py_d;
            end
        end
    end

    // S2: Eij = (xj-xi)*(py-yi) - (yj-yi)*(px-xi); area = E01 evaluated at v2
    logic signed [EW-1:0] e_d [2][3];
    logic [1:0]           area_nz_d;
    logic signed [PW-1:0] m_a, m_b;
    logic signed [EW-1:0] area;

    always_comb begin
        m_a       = '0;
        m_b       = '0;
        area      = '0;
        area_nz_d = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                m_a        = ex_q[p][i] * py_q[p][i];
                m_b        = ey_q[p][i] * px_q[p][i];
                e_d[p][i]  = m_a - m_b;
            end
            m_a          = ey_q[p][0] * ex_q[p][2];
            m_b          = ex_q[p][0] * ey_q[p][2];
            area         = m_a - m_b;
            area_nz_d[p] = (area != '0);
        end
    end

    logic                 v2_q;
    logic signed [EW-1:0] e_q [2][3];
    logic [1:0]           area_nz_q;
    logic [2*COLOR_W-1:0] col2_q;
    logic [2*DEPTH_W-1:0] dep2_q;
    logic [COLOR_W-1:0]   bg2_q;
    logic                 scr2_q;
    logic [1:0]           en2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q      <= 1'b0;
            area_nz_q <= '0;
            col2_q    <= '0;
            dep2_q    <= '0;
            bg2_q     <= '0;
            scr2_q    <= 1'b0;
            en2_q     <= '0;
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < 3; i++) begin
                    e_q[p][i] <= '0;
                end
            end
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                e_q       <= e_d;
                area_nz_q <= area_nz_d;
                col2_q    <= col1_q;
                dep2_q    <= dep1_q;
                bg2_q     <= bg1_q;
                scr2_q    <= scr1_q;
                en2_q     <= en1_q;
            end
        end
    end

    // S3: winding-independent coverage, then depth resolve (tie goes to A)
    logic [1:0]         cov;
    logic [COLOR_W-1:0] color_d;

    always_comb begin
        cov = '0;
        for (int p = 0; p < 2; p++) begin
            cov[p] = en2_q[p] & area_nz_q[p] &
                     (((e_q[p][0] >= 0) & (e_q[p][1] >= 0) & (e_q[p][2] >= 0)) |
                      ((e_q[p][0] <= 0) & (e_q[p][1] <= 0) & (e_q[p][2] <= 0)));
        end
        color_d = bg2_q;
        if (!scr2_q) begin
            color_d = '0;
        end else if (cov[0] && cov[1]) begin
            color_d = (dep2_q[2*DEPTH_W-1:DEPTH_W] < dep2_q[DEPTH_W-1:0]) ?
                      col2_q[2*COLOR_W-1:COLOR_W] : col2_q[COLOR_W-1:0];
        end else if (cov[0]) begin
            color_d = col2_q[COLOR_W-1:0];
        end else if (cov[1]) begin
            color_d = col2_q[2*COLOR_W-1:COLOR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_out   <= '0;
            color_valid <= 1'b0;
        end else begin
            color_valid <= v2_q;
            if (v2_q) begin
                color_out <= color_d;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_emern_rasterizer.sv
// Directed bench for the rasterizer: hand-computed colours for coverage, depth, winding,
// snapshot timing and mid-stream reset.
module tb_tt_um_emern_rasterizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pixel_valid;
    logic [6:0]  pixel_x;
    logic [5:0]  pixel_y;
    logic [5:0]  bg_color_in;
    logic [11:0] poly_color_in;
    logic [13:0] v0_x_in, v1_x_in, v2_x_in;
    logic [11:0] v0_y_in, v1_y_in, v2_y_in;
    logic [5:0]  poly_depth_in;
    logic        en_screen_in;
    logic [1:0]  poly_enable_in;
    logic [5:0]  color_out;
    logic        color_valid;

    int n_cmp = 0;
    int n_err = 0;

    tt_um_emern_rasterizer dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .pixel_valid    (pixel_valid),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .bg_color_in    (bg_color_in),
        .poly_color_in  (poly_color_in),
        .v0_x_in        (v0_x_in),
        .v1_x_in        (v1_x_in),
        .v2_x_in        (v2_x_in),
        .v0_y_in        (v0_y_in),
        .v1_y_in        (v1_y_in),
        .v2_y_in        (v2_y_in),
        .poly_depth_in  (poly_depth_in),
        .en_screen_in   (en_screen_in),
        .poly_enable_in (poly_enable_in),
        .color_out      (color_out),
        .color_valid    (color_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tri(input int p, input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int col, input int dep);
        v0_x_in[p*7 +: 7]       = 7'(x0);
        v0_y_in[p*6 +: 6]       = 6'(y0);
        v1_x_in[p*7 +: 7]       = 7'(x1);
        v1_y_in[p*6 +: 6]       = 6'(y1);
        v2_x_in[p*7 +: 7]       = 7'(x2);
        v2_y_in[p*6 +: 6]       = 6'(y2);
        poly_color_in[p*6 +: 6] = 6'(col);
        poly_depth_in[p*3 +: 3] = 3'(dep);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // One isolated pixel: checks that it is not early and arrives exactly three edges later
    task automatic pix(input string tag, input int x, input int y, input logic [5:0] exp);
        pixel_valid = 1'b1;
        pixel_x     = 7'(x);
        pixel_y     = 6'(y);
        step();
        pixel_valid = 1'b0;
        step();
        check_eq({tag, " early"}, 32'(color_valid), 32'd0);
        step();
        check_eq({tag, " valid"}, 32'(color_valid), 32'd1);
        check_eq(tag, 32'(color_out), 32'(exp));
    endtask

    initial begin
        rst            = 1'b1;
        frame_start    = 1'b0;
        pixel_valid    = 1'b0;
        pixel_x        = '0;
        pixel_y        = '0;
        bg_color_in    = 6'h03;
        poly_color_in  = '0;
        v0_x_in        = '0;
        v1_x_in        = '0;
        v2_x_in        = '0;
        v0_y_in        = '0;
        v1_y_in        = '0;
        v2_y_in        = '0;
        poly_depth_in  = '0;
        en_screen_in   = 1'b1;
        poly_enable_in = 2'b01;
        set_tri(0, 10, 5, 40, 5, 10, 30, 6'h30, 4);
        set_tri(1, 5, 2, 60, 2, 5, 40, 6'h0C, 2);
        step();
        step();
        check_eq("rst color_out", 32'(color_out), 32'd0);
        check_eq("rst color_valid", 32'(color_valid), 32'd0);
        rst = 1'b0;
        step();

        // Inputs are configured but never snapshotted: screen stays off
        pix("t1 noframe a", 12, 7, 6'h00);
        pix("t1 noframe b", 50, 50, 6'h00);

        pulse_frame();
        pix("t2 inside", 12, 7, 6'h30);
        pix("t2 outside", 50, 50, 6'h03);
        pix("t2 vertex", 40, 5, 6'h30);
        pix("t2 edge", 25, 5, 6'h30);

        poly_enable_in = 2'b11;
        pulse_frame();
        pix("t3 B closer", 12, 7, 6'h0C);
        pix("t3 B only", 50, 5, 6'h0C);
        set_tri(1, 5, 2, 60, 2, 5, 40, 6'h0C, 4);
        pulse_frame();
        pix("t3 tie", 12, 7, 6'h30);
        set_tri(1, 5, 2, 60, 2, 5, 40, 6'h0C, 6);
        pulse_frame();
        pix("t3 A closer", 12, 7, 6'h30);

        poly_enable_in = 2'b01;
        set_tri(0, 10, 5, 10, 30, 40, 5, 6'h30, 4);
        pulse_frame();
        pix("t4 cw inside", 12, 7, 6'h30);
        pix("t4 cw outside", 50, 50, 6'h03);
        pix("t4 cw vertex", 40, 5, 6'h30);
        set_tri(0, 0, 0, 10, 10, 20, 20, 6'h30, 4);
        pulse_frame();
        pix("t4 collinear on", 5, 5, 6'h03);
        pix("t4 collinear off", 12, 7, 6'h03);

        set_tri(0, 10, 5, 40, 5, 10, 30, 6'h30, 4);
        pulse_frame();
        poly_color_in[5:0] = 6'h3F;
        pix("t5 no frame", 12, 7, 6'h30);
        pixel_valid = 1'b1;
        pixel_x     = 7'd12;
        pixel_y     = 6'd7;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        step();
        check_eq("t5 before fs valid", 32'(color_valid), 32'd1);
        check_eq("t5 before fs", 32'(color_out), 32'h30);
        step();
        check_eq("t5 with fs valid", 32'(color_valid), 32'd1);
        check_eq("t5 with fs", 32'(color_out), 32'h3F);

        // Back-to-back stream, reset on the fourth pixel
        pixel_x = 7'd12;
        pixel_y = 6'd7;
        for (int i = 0; i < 8; i++) begin
            pixel_valid = 1'b1;
            rst         = (i == 3);
            step();
            if (i >= 3 && i <= 5) begin
                check_eq($sformatf("t6 flushed %0d", i), 32'(color_valid), 32'd0);
            end else if (i >= 6) begin
                check_eq($sformatf("t6 valid %0d", i), 32'(color_valid), 32'd1);
                check_eq($sformatf("t6 black %0d", i), 32'(color_out), 32'd0);
            end
        end
        rst         = 1'b0;
        pixel_valid = 1'b0;
        for (int i = 8; i < 10; i++) begin
            step();
            check_eq($sformatf("t6 valid %0d", i), 32'(color_valid), 32'd1);
            check_eq($sformatf("t6 black %0d", i), 32'(color_out), 32'd0);
        end
        step();
        check_eq("t6 drained", 32'(color_valid), 32'd0);
        check_eq("t6 hold", 32'(color_out), 32'd0);
        pulse_frame();
        pix("t6 after frame", 12, 7, 6'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
